// File: rtl/vec_mem_seq_if.sv
// rtl/vec_mem_seq_if.sv - core request/response and memory bus bundle for vec_mem_seq (stride port only with VEC_STRIDE_EN)
interface vec_mem_seq_if #(
  parameter int NELEM = 16,
  parameter int EW    = 16
) ();
  logic                  start;
  logic                  op;
  logic [15:0]           base;
`ifdef VEC_STRIDE_EN
  logic [15:0]           stride;
`endif
  logic [NELEM*EW-1:0]   vec_in;
  logic [NELEM*EW-1:0]   vec_out;
  logic                  busy;
  logic                  done;
  logic [15:0]           Addr;
  logic                  RD;
  logic                  WR;
  logic [EW-1:0]         DataOut;
  logic [EW-1:0]         DataIn;

  modport slave (
`ifdef VEC_STRIDE_EN
    input  stride,
`endif
    input  start, op, base, vec_in, DataIn,
    output vec_out, busy, done, Addr, RD, WR, DataOut
  );

  modport master (
`ifdef VEC_STRIDE_EN
    output stride,
`endif
    output start, op, base, vec_in, DataIn,
    input  vec_out, busy, done, Addr, RD, WR, DataOut
  );
endinterface

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - vector load/store sequencer, one memory word per cycle; VEC_STRIDE_EN adds a strided address stream
module vec_mem_seq #(
  parameter int NELEM = 16,
  parameter int EW    = 16
) (
  input  logic           Clk1,
  input  logic           Reset,
  vec_mem_seq_if.slave   bus
);
  localparam int KW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NELEM - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LDRAIN, S_STORE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NELEM-1:0][EW-1:0] vec_q, vec_d;
  logic [NELEM-1:0][EW-1:0] vout_q, vout_d;
  logic [15:0]             addr_q, addr_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [EW-1:0]           dout_q, dout_d;
  logic [15:0]             stride_w;

`ifdef VEC_STRIDE_EN
  logic [15:0]             stride_q, stride_d;
  assign stride_w = stride_q;
`else
  assign stride_w = 16'd1;
`endif

  // addr_q doubles as the running address accumulator, so no base*stride product is ever formed
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vec_d   = vec_q;
    vout_d  = vout_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
`ifdef VEC_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d  = bus.vec_in;
          k_d    = '0;
          addr_d = bus.base;
`ifdef VEC_STRIDE_EN
          stride_d = bus.stride;
`endif
          if (bus.op) begin
            state_d = S_STORE;
            wr_d    = 1'b1;
            dout_d  = bus.vec_in[EW-1:0];
          end else begin
            state_d = S_LOAD;
            rd_d    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // read data trails the strobe by one cycle, so this cycle returns element k-1
        if (k_q != '0) vout_d[k_q - 1'b1] = bus.DataIn;
        if (k_q == K_LAST) begin
          state_d = S_LDRAIN;
          rd_d    = 1'b0;
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + stride_w;
        end
      end
      S_LDRAIN: begin
        vout_d[NELEM-1] = bus.DataIn;
        state_d         = S_DONE;
      end
      S_STORE: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          wr_d    = 1'b0;
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + stride_w;
          dout_d = vec_q[k_q + 1'b1];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      vec_q   <= '0;
      vout_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
`ifdef VEC_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      vout_q  <= vout_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
`ifdef VEC_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  assign bus.vec_out = vout_q;
  assign bus.busy    = (state_q == S_LOAD) || (state_q == S_LDRAIN) || (state_q == S_STORE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.Addr    = addr_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.DataOut = dout_q;
endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - scoreboard bench for vec_mem_seq with a behavioural memory/vector model
module tb_vec_mem_seq;
  logic Clk1;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  vec_mem_seq_if #(.NELEM(16), .EW(16)) bif ();

  vec_mem_seq #(.NELEM(16), .EW(16)) dut (
    .Clk1  (Clk1),
    .Reset (Reset),
    .bus   (bif.slave)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;
  always @(posedge Clk1) cyc++;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_t;

  typedef struct {
    int           lat;
    int           start_cyc;
    logic [255:0] vec;
  } txn_t;

  bus_t         busq[$];
  txn_t         txq[$];
  logic [15:0]  ref_mem [0:65535];
  logic [255:0] vec_model;

  // initial memory image chosen so that word 16'h0100+i holds 16'hA000+i
  function automatic logic [15:0] mem_init(input int a);
    logic [15:0] w;
    w = 16'(a);
    return w + 16'h9F00;
  endfunction

  initial begin
    logic [15:0] mem [0:65535];
    for (int a = 0; a < 65536; a++) mem[a] = mem_init(a);
    bif.DataIn = '0;
    forever begin
      @(posedge Clk1);
      if (bif.RD) bif.DataIn <= mem[bif.Addr];
      if (bif.WR) mem[bif.Addr] <= bif.DataOut;
    end
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk1) begin
    if (!Reset) begin
      if (bif.RD || bif.WR) begin
        if (busq.size() == 0) begin
          check("bus_unexpected", {bif.WR, bif.RD, bif.Addr}, '0);
        end else begin
          bus_t e;
          e = busq.pop_front();
          check("strobe_excl", {bif.RD, bif.WR}, {~e.wr, e.wr});
          check("bus_cycle", {bif.WR, bif.Addr, (bif.WR ? bif.DataOut : 16'h0)}, {e.wr, e.addr, e.data});
        end
      end
      if (bif.done) begin
        if (txq.size() == 0) begin
          check("done_unexpected", bif.done, 1'b0);
        end else begin
          txn_t t;
          t = txq.pop_front();
          check("done_latency", cyc - t.start_cyc, t.lat);
          check("vec_out", bif.vec_out, t.vec);
          check("busy_in_done", bif.busy, 1'b0);
          check("bus_drained", busq.size(), 0);
        end
      end
    end
  end

  task automatic issue(input logic op_v, input logic [15:0] base_v, input logic [15:0] stride_v,
                       input logic [255:0] vin);
    logic [255:0] ld;
    logic [15:0]  a;
    txn_t         t;
    @(negedge Clk1);
    ld = vec_model;
    for (int i = 0; i < 16; i++) begin
      a = base_v + 16'(i) * stride_v;
      if (op_v) begin
        busq.push_back('{1'b1, a, vin[i*16 +: 16]});
        ref_mem[a] = vin[i*16 +: 16];
      end else begin
        busq.push_back('{1'b0, a, 16'h0});
        ld[i*16 +: 16] = ref_mem[a];
      end
    end
    if (!op_v) vec_model = ld;
    t.lat       = op_v ? 17 : 18;
    t.start_cyc = cyc;
    t.vec       = vec_model;
    txq.push_back(t);
    bif.op     = op_v;
    bif.base   = base_v;
    bif.vec_in = vin;
`ifdef VEC_STRIDE_EN
    bif.stride = stride_v;
`endif
    bif.start  = 1'b1;
    @(negedge Clk1);
    bif.start  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (txq.size() != 0 && n < 300) begin
      @(negedge Clk1);
      n++;
    end
    check("drain_timeout", txq.size(), 0);
    @(negedge Clk1);
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] v;
    logic [15:0]  s;
    for (int a = 0; a < 65536; a++) ref_mem[a] = mem_init(a);
    vec_model  = '0;
    bif.start  = 1'b0;
    bif.op     = 1'b0;
    bif.base   = '0;
    bif.vec_in = '0;
`ifdef VEC_STRIDE_EN
    bif.stride = 16'd1;
`endif
    Reset = 1'b1;
    repeat (3) @(negedge Clk1);
    bif.start = 1'b1;
    @(negedge Clk1);
    check("reset_outputs", {bif.busy, bif.done, bif.RD, bif.WR, bif.Addr, bif.DataOut}, '0);
    check("reset_vec_out", bif.vec_out, '0);
    Reset     = 1'b0;
    bif.start = 1'b0;
    @(negedge Clk1);
    check("reset_beats_start", {bif.busy, bif.RD}, 2'b00);

    // directed load, store, read-back and address wrap
    issue(1'b0, 16'h0100, 16'd1, '0);
    drain();
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h5A00 + 16'(i);
    issue(1'b1, 16'h0200, 16'd1, v);
    drain();
    issue(1'b0, 16'h0200, 16'd1, '0);
    drain();
    issue(1'b0, 16'hFFF8, 16'd1, '0);
    drain();

    // second start during a load must be dropped
    issue(1'b0, 16'h0300, 16'd1, '0);
    repeat (4) @(negedge Clk1);
    bif.op = 1'b1; bif.base = 16'h0400; bif.vec_in = rand_vec(); bif.start = 1'b1;
    @(negedge Clk1);
    bif.start = 1'b0;
    drain();
    repeat (20) @(negedge Clk1);
    issue(1'b1, 16'h0500, 16'd1, rand_vec());
    drain();

    // reset during a load
    issue(1'b0, 16'h0600, 16'd1, '0);
    repeat (7) @(negedge Clk1);
    Reset = 1'b1;
    @(negedge Clk1);
    check("midreset_outputs", {bif.busy, bif.done, bif.RD, bif.WR, bif.Addr}, '0);
    check("midreset_vec_out", bif.vec_out, '0);
    Reset = 1'b0;
    busq.delete();
    txq.delete();
    vec_model = '0;
    @(negedge Clk1);
    issue(1'b0, 16'h0610, 16'd1, '0);
    drain();

`ifdef VEC_STRIDE_EN
    issue(1'b0, 16'h0010, 16'h0004, '0);
    drain();
    issue(1'b0, 16'h0010, 16'h0000, '0);
    drain();
`endif

    for (int r = 0; r < 10; r++) begin
`ifdef VEC_STRIDE_EN
      s = 16'($urandom_range(0, 300));
`else
      s = 16'd1;
`endif
      issue(1'($urandom_range(0, 1)), 16'($urandom), s, rand_vec());
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
